// File: rtl/btb_redirect_ctrl_pkg.sv
// Shared opcodes, condition encodings and controller state for the BTB redirect controller.
package btb_redirect_ctrl_pkg;
  localparam int DEF_PC_W = 16;
  localparam logic [3:0] OP_BR       = 4'b1001;
  localparam logic [3:0] OP_JMP      = 4'b1010;
  localparam logic [2:0] COND_ALWAYS = 3'b111;

  typedef enum logic {RUN, FLUSH} state_t;

  // Actual branch direction; non-branch opcodes report not-taken.
  function automatic logic br_taken(input logic [3:0] op, input logic [2:0] cond,
                                    input logic g, input logic z, input logic l);
    if (op == OP_JMP) return 1'b1;
    if (op != OP_BR) return 1'b0;
    return (cond == COND_ALWAYS) || (|(cond & {g, z, l}));
  endfunction
endpackage

// File: rtl/btb_redirect_ctrl_if.sv
// Fetch/EX inputs and redirect/BTB-write outputs of the redirect controller.
interface btb_redirect_ctrl_if #(parameter int PC_W = 16);
  logic            stall;
  logic            btb_prediction;
  logic [PC_W-1:0] btb_target;
  logic            ex_valid;
  logic [PC_W-1:0] ex_pc;
  logic [3:0]      ex_opcode;
  logic [2:0]      ex_cond;
  logic [PC_W-1:0] target_entry;
  logic            gflag, zflag, lflag;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic            flush;
  logic            btb_wr_en;
  logic [PC_W-1:0] btb_wr_pc;
  logic [PC_W-1:0] btb_wr_target;
  logic            btb_wr_taken;
  logic [15:0]     mispredict_cnt;

  modport slave (
    input  stall, btb_prediction, btb_target, ex_valid, ex_pc, ex_opcode, ex_cond,
           target_entry, gflag, zflag, lflag,
    output redirect_valid, redirect_pc, flush, btb_wr_en, btb_wr_pc, btb_wr_target,
           btb_wr_taken, mispredict_cnt
  );
  modport master (
    output stall, btb_prediction, btb_target, ex_valid, ex_pc, ex_opcode, ex_cond,
           target_entry, gflag, zflag, lflag,
    input  redirect_valid, redirect_pc, flush, btb_wr_en, btb_wr_pc, btb_wr_target,
           btb_wr_taken, mispredict_cnt
  );
endinterface

// File: rtl/btb_redirect_ctrl_pred_pipe.sv
// Carries fetch-time BTB predictions down to EX; frozen on stall, zeroed while flushing.
module btb_pred_pipe #(
  parameter int PC_W  = 16,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            in_pred,
  input  logic [PC_W-1:0] in_target,
  output logic            out_pred,
  output logic [PC_W-1:0] out_target
);
  logic [DEPTH-1:0]           pred_q;
  logic [DEPTH-1:0][PC_W-1:0] tgt_q;

  // Flush wins over stall so wrong-path predictions never survive a redirect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pred_q <= '0;
      tgt_q  <= '0;
    end else if (flush) begin
      pred_q <= '0;
      tgt_q  <= '0;
    end else if (!stall) begin
      pred_q[0] <= in_pred;
      tgt_q[0]  <= in_target;
      for (int i = 1; i < DEPTH; i++) begin
        pred_q[i] <= pred_q[i-1];
        tgt_q[i]  <= tgt_q[i-1];
      end
    end
  end

  assign out_pred   = pred_q[DEPTH-1];
  assign out_target = tgt_q[DEPTH-1];
endmodule

// File: rtl/btb_redirect_ctrl.sv
// Resolves EX branches against their fetch-time BTB prediction; drives redirect, flush and BTB training.
module btb_redirect_ctrl
  import btb_redirect_ctrl_pkg::*;
#(
  parameter int PC_W         = DEF_PC_W,
  parameter int PRED_DEPTH   = 2,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  btb_redirect_ctrl_if.slave     bus
);
  localparam int FC_W = $clog2(FLUSH_CYCLES + 1);

  state_t          state;
  logic [FC_W-1:0] flush_left;
  logic            tok_pred;
  logic [PC_W-1:0] tok_tgt;
  logic            is_branch, taken, resolve;
  logic            mis_take, mis_nt, mis_alias, mispredict;
  logic [PC_W-1:0] pc_inc;

  btb_pred_pipe #(.PC_W(PC_W), .DEPTH(PRED_DEPTH)) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .stall     (bus.stall),
    .flush     (bus.flush),
    .in_pred   (bus.btb_prediction),
    .in_target (bus.btb_target),
    .out_pred  (tok_pred),
    .out_target(tok_tgt)
  );

  assign is_branch  = (bus.ex_opcode == OP_BR) || (bus.ex_opcode == OP_JMP);
  assign taken      = br_taken(bus.ex_opcode, bus.ex_cond, bus.gflag, bus.zflag, bus.lflag);
  assign resolve    = (state == RUN) && bus.ex_valid && !bus.stall;
  assign pc_inc     = bus.ex_pc + PC_W'(1);
  assign mis_take   = is_branch && taken && (!tok_pred || (tok_tgt != bus.target_entry));
  assign mis_nt     = is_branch && !taken && tok_pred;
  assign mis_alias  = !is_branch && tok_pred;
  assign mispredict = mis_take || mis_nt || mis_alias;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= RUN;
      flush_left         <= '0;
      bus.redirect_valid <= 1'b0;
      bus.redirect_pc    <= '0;
      bus.flush          <= 1'b0;
      bus.btb_wr_en      <= 1'b0;
      bus.btb_wr_pc      <= '0;
      bus.btb_wr_target  <= '0;
      bus.btb_wr_taken   <= 1'b0;
      bus.mispredict_cnt <= '0;
    end else begin
      bus.redirect_valid <= 1'b0;
      bus.btb_wr_en      <= 1'b0;
      case (state)
        RUN: begin
          if (resolve && mispredict) begin
            bus.redirect_valid <= 1'b1;
            bus.redirect_pc    <= mis_take ? bus.target_entry : pc_inc;
            bus.btb_wr_en      <= 1'b1;
            bus.btb_wr_pc      <= bus.ex_pc;
            bus.btb_wr_target  <= mis_alias ? '0 : bus.target_entry;
            bus.btb_wr_taken   <= mis_take;
            bus.flush          <= 1'b1;
            flush_left         <= FC_W'(FLUSH_CYCLES - 1);
            state              <= FLUSH;
            if (bus.mispredict_cnt != 16'hFFFF)
              bus.mispredict_cnt <= bus.mispredict_cnt + 16'd1;
          end else if (resolve && is_branch) begin
            // Correct prediction still trains, reinforcing the entry.
            bus.btb_wr_en     <= 1'b1;
            bus.btb_wr_pc     <= bus.ex_pc;
            bus.btb_wr_target <= bus.target_entry;
            bus.btb_wr_taken  <= taken;
          end
        end
        FLUSH: begin
          if (flush_left == '0) begin
            bus.flush <= 1'b0;
            state     <= RUN;
          end else begin
            flush_left <= flush_left - FC_W'(1);
          end
        end
        default: state <= RUN;
      endcase
    end
  end
endmodule
